// File: rtl/debug_dump_tx.sv
// -----------------------------------------------------------------------------
// debug_dump_tx
//
// Streams a snapshot of a flat register file as a framed byte stream over a
// valid/ready handshake. A frame is:
//   0xA5 header, then every register 0..r-1 most-significant byte first,
//   then one checksum byte (XOR of all data bytes, header excluded).
// The register image is captured when Start is accepted in IDLE, so later
// changes on DebugData do not disturb a frame in flight.
//
// Parameters
//   l         register width in bits (multiple of 8)
//   a         register address width; register count r = 2**a
//
// Ports
//   Clk       clock, all state changes on the rising edge
//   Reset     synchronous active-high reset
//   DebugData flat register image, register i at [i*l +: l]
//   Start     dump request, honoured only in IDLE
//   OutByte   current stream byte (0x00 when idle)
//   OutValid  OutByte valid
//   InReady   downstream accepts OutByte this cycle
//   Busy      frame in progress
//   Done      one-cycle pulse the cycle after the checksum transfers
// -----------------------------------------------------------------------------
module debug_dump_tx #(
  parameter int l = 16,
  parameter int a = 3
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [l*(2**a)-1:0]   DebugData,
  input  logic                  Start,
  output logic [7:0]            OutByte,
  output logic                  OutValid,
  input  logic                  InReady,
  output logic                  Busy,
  output logic                  Done
);

  localparam int R   = 2 ** a;
  localparam int BPR = l / 8;
  localparam int NB  = R * BPR;
  localparam int IW  = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
  localparam logic [7:0]    HDR_BYTE = 8'hA5;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_HEADER   = 2'd1;
  localparam logic [1:0] S_DATA     = 2'd2;
  localparam logic [1:0] S_CHECKSUM = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      csum_q, csum_d;
  logic            done_q, done_d;
  logic [l*R-1:0]  snap_q;

  logic [7:0]      data_bytes [NB];
  logic [7:0]      data_byte;
  logic            accept_start;

  // Byte k of the stream is byte (k % BPR) of register (k / BPR), counted
  // from the most-significant end; flatten that ordering once here so the
  // DATA state only needs a linear index.
  for (genvar gr = 0; gr < R; gr++) begin : g_reg
    for (genvar gb = 0; gb < BPR; gb++) begin : g_byte
      assign data_bytes[gr*BPR + gb] = snap_q[gr*l + l - 8 - 8*gb +: 8];
    end
  end

  assign data_byte    = data_bytes[idx_q];
  assign accept_start = (state_q == S_IDLE) && Start;

  // Next-state logic. Index and checksum only move on an actual transfer,
  // which in every non-idle state is simply InReady (OutValid is high).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_HEADER;
          idx_d   = '0;
          csum_d  = '0;
        end
      end
      S_HEADER: begin
        if (InReady) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (InReady) begin
          csum_d = csum_q ^ data_byte;
          if (idx_q == LAST_IDX) begin
            state_d = S_CHECKSUM;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_CHECKSUM: begin
        if (InReady) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
    end
  end

  // Snapshot carries no reset: it is always reloaded before being emitted.
  always_ff @(posedge Clk) begin
    if (!Reset && accept_start) begin
      snap_q <= DebugData;
    end
  end

  // Outputs decode straight from registered state, so they hold steady
  // for as long as the downstream stalls.
  always_comb begin
    OutByte = 8'h00;
    case (state_q)
      S_HEADER:   OutByte = HDR_BYTE;
      S_DATA:     OutByte = data_byte;
      S_CHECKSUM: OutByte = csum_q;
      default:    OutByte = 8'h00;
    endcase
  end

  assign OutValid = (state_q != S_IDLE);
  assign Busy     = (state_q != S_IDLE);
  assign Done     = done_q;

endmodule

// File: doc/debug_dump_tx.md
DEBUG_DUMP_TX -- requirements
Module: debug_dump_tx

Interface
REQ-001 SHALL have parameter l, default 16: register width in bits; SHALL be a multiple of 8.
REQ-002 SHALL have parameter a, default 3: register address width; register count r = 2^a.
REQ-003 SHALL have port Clk, input, 1: single clock; all state changes on posedge Clk.
REQ-004 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port DebugData, input, l*r: flat register-file image; register i occupies bits [i*l +: l].
REQ-006 SHALL have port Start, input, 1: dump request, sampled each cycle.
REQ-007 SHALL have port OutByte, output, 8: current stream byte.
REQ-008 SHALL have port OutValid, output, 1: OutByte valid.
REQ-009 SHALL have port InReady, input, 1: downstream accepts OutByte.
REQ-010 SHALL have port Busy, output, 1: frame in progress.
REQ-011 SHALL have port Done, output, 1: one-cycle pulse at frame end.

Function
REQ-012 SHALL transfer a byte only on a cycle with OutValid=1 and InReady=1.
REQ-013 SHALL hold OutByte stable while OutValid=1 and InReady=0; OutValid SHALL NOT drop before the transfer.
REQ-014 SHALL implement states IDLE, HEADER, DATA, CHECKSUM.
REQ-015 In IDLE with Start=1, SHALL copy DebugData into an internal snapshot and enter HEADER on the same edge.
REQ-016 SHALL assert OutValid and Busy the cycle after Start is sampled (latency 1).
REQ-017 SHALL ignore Start in every state other than IDLE.
REQ-018 HEADER SHALL emit 0xA5; on transfer, enter DATA with byte index 0.
REQ-019 DATA SHALL emit the snapshot registers 0..r-1 in order, each most-significant byte first: r*(l/8) bytes total (16 at defaults).
REQ-020 The DATA byte index SHALL advance only on transfer; after the last data byte transfers, SHALL enter CHECKSUM.
REQ-021 CHECKSUM SHALL emit the XOR of all DATA bytes; the header SHALL NOT be included.
REQ-022 SHALL accumulate the checksum on each DATA transfer, starting from 0x00 at frame start.
REQ-023 On the CHECKSUM transfer, SHALL return to IDLE and pulse Done=1 on the next cycle.
REQ-024 During that Done cycle, SHALL drive Busy=0 and OutValid=0.
REQ-025 Frame length SHALL be r*(l/8)+2 bytes (18 at defaults); the minimum frame time with InReady tied high SHALL be 18 cycles.
REQ-026 SHALL ignore changes on DebugData after the snapshot until the next accepted Start.
REQ-027 In IDLE, SHALL drive OutValid=0, Busy=0 and OutByte=0x00.
REQ-028 Start sampled in the Done cycle (state is IDLE) SHALL begin a new frame.

Reset
REQ-029 On Reset=1 at a clock edge, SHALL enter IDLE and clear OutValid, Busy, Done, OutByte, the byte index and the checksum, all to 0.
REQ-030 Reset SHALL take priority over Start and over any in-progress transfer.
REQ-031 Reset mid-frame SHALL abort the frame with no Done pulse; OutValid SHALL be 0 the cycle after reset.
REQ-032 Snapshot contents after reset are don't-care; they are never emitted before a new Start.

Verification
REQ-033 Dump, no backpressure: registers all 0 except R1=0x1234 and R7=0x00FF; InReady=1; pulse Start -> bytes A5,00,00,12,34,00×10,00,FF,D9 on 18 consecutive cycles; Done one cycle after D9.
REQ-034 Backpressure: InReady=0 for 3 cycles while byte 5 (0x00 of R2) is presented -> OutByte and OutValid held stable; no skipped or duplicated bytes; Done delayed by 3 cycles.
REQ-035 Snapshot isolation: change DebugData R1 to 0xBEEF two cycles after Start -> frame still carries 12,34 and checksum D9.
REQ-036 Start while busy: pulse Start at byte 8 -> same 18-byte frame and one Done pulse; no second frame.
REQ-037 Reset mid-frame: assert Reset after byte 10 -> OutValid=0 and Busy=0 the next cycle, no Done; then Start -> full correct 18-byte frame.
REQ-038 Back-to-back: Start high continuously with InReady=1 -> a new header A5 the cycle after Done; two identical frames.
